// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pattern generator: pattern mode enum,
// 8-entry band colour table, default 800x600@60 timing and band threshold helper.
package vga_pkg;

  typedef enum logic [1:0] {
    H_BARS  = 2'd0,
    V_BARS  = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } vga_mode_e;

  // {r,g,b} on/off per band: black, red, yellow, green, cyan, blue, magenta, white
  localparam logic [2:0] COLOR_TABLE [8] = '{
    3'b000, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b111
  };

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  // Smallest coordinate c with c*8/active >= k, so band = number of thresholds passed.
  function automatic int band_threshold(input int k, input int active);
    return (k * active + 7) / 8;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus registered sync, display-enable, pixel coordinates and
// frame_start. Registered outputs describe the counter values of the previous cycle.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        running,
  output logic        active,
  output logic        at_origin,
  output logic        h_sync,
  output logic        v_sync,
  output logic        de,
  output logic        frame_start,
  output logic [11:0] px_x,
  output logic [10:0] px_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ON  = (SYNC_POL != 0);

  logic h_wrap;
  logic hs_now;
  logic vs_now;

  always_comb begin
    h_wrap    = (h_cnt == H_LAST);
    active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_now    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_now    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    at_origin = (h_cnt == 12'd0) && (v_cnt == 11'd0);
  end

  // The first edge after reset release only arms the counters, so (0,0) is
  // presented on the second edge and frame_start lands one clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (!running) begin
      running <= 1'b1;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sync      <= ~SYNC_ON;
      v_sync      <= ~SYNC_ON;
      de          <= 1'b0;
      frame_start <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
    end else if (running) begin
      h_sync      <= hs_now ? SYNC_ON : ~SYNC_ON;
      v_sync      <= vs_now ? SYNC_ON : ~SYNC_ON;
      de          <= active;
      frame_start <= at_origin;
      px_x        <= active ? h_cnt : 12'd0;
      px_y        <= active ? v_cnt : 11'd0;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: timing from vga_timing plus registered colour for
// bars, checkerboard and solid modes. Define VGA_BORDER_EN for a white frame border.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_POL   = 1,
  parameter int COLOR_W    = 1,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   de,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic [11:0]            px_x,
  output logic [10:0]            px_y,
  output logic                   frame_start
);

  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        running;
  logic        active;
  logic        at_origin;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .running     (running),
    .active      (active),
    .at_origin   (at_origin),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .de          (de),
    .frame_start (frame_start),
    .px_x        (px_x),
    .px_y        (px_y)
  );

  function automatic logic [3*COLOR_W-1:0] expand(input logic [2:0] c);
    return {{COLOR_W{c[2]}}, {COLOR_W{c[1]}}, {COLOR_W{c[0]}}};
  endfunction

  vga_mode_e             mode_q;
  vga_mode_e             mode_eff;
  logic [3*COLOR_W-1:0]  solid_q;
  logic [3*COLOR_W-1:0]  solid_eff;
  logic [2:0]            h_band;
  logic [2:0]            v_band;
  logic [3*COLOR_W-1:0]  pix;
  logic [3*COLOR_W-1:0]  rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= H_BARS;
      solid_q <= '0;
    end else if (at_origin) begin
      mode_q  <= vga_mode_e'(mode);
      solid_q <= solid_rgb;
    end
  end

  // Pixel (0,0) is the latch point, so it already uses the freshly sampled inputs.
  always_comb begin
    mode_eff  = at_origin ? vga_mode_e'(mode) : mode_q;
    solid_eff = at_origin ? solid_rgb : solid_q;
  end

  always_comb begin
    h_band = 3'd0;
    v_band = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= 12'(band_threshold(k, H_ACTIVE))) h_band = h_band + 3'd1;
      if (v_cnt >= 11'(band_threshold(k, V_ACTIVE))) v_band = v_band + 3'd1;
    end
  end

  always_comb begin
    pix = '0;
    case (mode_eff)
      H_BARS:  pix = expand(COLOR_TABLE[v_band]);
      V_BARS:  pix = expand(COLOR_TABLE[h_band]);
      CHECKER: pix = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? expand(3'b111) : '0;
      SOLID:   pix = solid_eff;
      default: pix = '0;
    endcase
`ifdef VGA_BORDER_EN
    if ((h_cnt == 12'd0) || (h_cnt == 12'(H_ACTIVE - 1)) ||
        (v_cnt == 11'd0) || (v_cnt == 11'(V_ACTIVE - 1))) begin
      pix = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else if (running) begin
      rgb_q <= active ? pix : '0;
    end
  end

  assign vga_r = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_b = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed testbench for vga_pattern_gen on a tiny 16x8 raster (24x12 total).
// Border expectations follow VGA_BORDER_EN when the bench is built with it.
module tb_vga_pattern_gen;

  localparam int HT = 24;
  localparam int VT = 12;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [5:0]  solid_rgb = 6'd0;
  logic        h_sync, v_sync, de, frame_start;
  logic [1:0]  vga_r, vga_g, vga_b;
  logic [11:0] px_x;
  logic [10:0] px_y;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1), .COLOR_W(2), .CHECK_LOG2(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
    .h_sync(h_sync), .v_sync(v_sync), .de(de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .px_x(px_x), .px_y(px_y), .frame_start(frame_start)
  );

  function automatic logic [5:0] bar_color(input int band);
    case (band)
      0: return 6'b00_00_00;
      1: return 6'b11_00_00;
      2: return 6'b11_11_00;
      3: return 6'b00_11_00;
      4: return 6'b00_11_11;
      5: return 6'b00_00_11;
      6: return 6'b11_00_11;
      default: return 6'b11_11_11;
    endcase
  endfunction

  // Expected colour of a visible pixel on the 16x8 bench raster.
  function automatic logic [5:0] exp_color(input logic [1:0] m, input logic [5:0] s,
                                           input int x, input int y);
`ifdef VGA_BORDER_EN
    if (x == 0 || x == 15 || y == 0 || y == 7) return 6'h3f;
`endif
    case (m)
      2'd0: return bar_color(y);
      2'd1: return bar_color(x / 2);
      2'd2: return (((x / 4) ^ (y / 4)) & 1) != 0 ? 6'h3f : 6'h00;
      default: return s;
    endcase
  endfunction

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL frame_start_timeout: no frame_start within 400 cycles, required one per %0d", FRAME);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({h_sync, v_sync, de, vga_r, vga_g, vga_b, px_x, px_y, frame_start} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: hs=%b vs=%b de=%b rgb=%h px=(%0d,%0d) fs=%b, required all 0",
               h_sync, v_sync, de, {vga_r, vga_g, vga_b}, px_x, px_y, frame_start);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0 || de !== 1'b0) begin
      failures++;
      $display("FAIL release_first_edge: fs=%b de=%b, required fs=0 de=0", frame_start, de);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || de !== 1'b1 || px_x !== 12'd0 || px_y !== 11'd0 ||
        {vga_r, vga_g, vga_b} !== exp_color(2'd0, 6'd0, 0, 0)) begin
      failures++;
      $display("FAIL release_second_edge: fs=%b de=%b px=(%0d,%0d) rgb=%h, required fs=1 de=1 px=(0,0) rgb=%h",
               frame_start, de, px_x, px_y, {vga_r, vga_g, vga_b}, exp_color(2'd0, 6'd0, 0, 0));
    end
  endtask

  // Two frames in H_BARS mode: sync windows, de, coordinates, bars and frame_start period.
  task automatic test_free_run();
    bit ok;
    int x, y, de_cnt0, de_cnt1, hs_cnt;
    bit vis, exp_hs, exp_vs, exp_fs;
    logic [5:0] exp_rgb;
    de_cnt0 = 0; de_cnt1 = 0; hs_cnt = 0;
    wait_frame_start(ok);
    if (!ok) return;
    for (int off = 0; off <= 2 * FRAME; off++) begin
      x = off % HT;
      y = (off / HT) % VT;
      vis = (x < 16) && (y < 8);
      exp_hs = (x >= 18) && (x < 21);
      exp_vs = (y >= 9) && (y < 11);
      exp_fs = (off % FRAME) == 0;
      exp_rgb = vis ? exp_color(2'd0, 6'd0, x, y) : 6'd0;
      checks++;
      if (h_sync !== exp_hs || v_sync !== exp_vs || de !== vis || frame_start !== exp_fs ||
          px_x !== (vis ? 12'(x) : 12'd0) || px_y !== (vis ? 11'(y) : 11'd0) ||
          {vga_r, vga_g, vga_b} !== exp_rgb) begin
        failures++;
        $display("FAIL free_run off=%0d: hs=%b vs=%b de=%b fs=%b px=(%0d,%0d) rgb=%h, required hs=%b vs=%b de=%b fs=%b px=(%0d,%0d) rgb=%h",
                 off, h_sync, v_sync, de, frame_start, px_x, px_y, {vga_r, vga_g, vga_b},
                 exp_hs, exp_vs, vis, exp_fs, vis ? x : 0, vis ? y : 0, exp_rgb);
      end
      if (off < FRAME && de === 1'b1) de_cnt0++;
      if (off >= FRAME && off < 2 * FRAME && de === 1'b1) de_cnt1++;
      if (off < FRAME && h_sync === 1'b1) hs_cnt++;
      if (off < 2 * FRAME) @(negedge clk);
    end
    checks++;
    if (de_cnt0 != 128 || de_cnt1 != 128) begin
      failures++;
      $display("FAIL de_count: frame0=%0d frame1=%0d, required 128 each", de_cnt0, de_cnt1);
    end
    checks++;
    if (hs_cnt != 3 * VT) begin
      failures++;
      $display("FAIL hsync_count: %0d, required %0d", hs_cnt, 3 * VT);
    end
  endtask

  task automatic test_v_bars();
    bit ok, vis;
    int x, y;
    logic [5:0] exp_rgb;
    mode = 2'd1;
    wait_frame_start(ok);
    if (!ok) return;
    for (int off = 0; off < FRAME; off++) begin
      x = off % HT;
      y = off / HT;
      vis = (x < 16) && (y < 8);
      exp_rgb = vis ? exp_color(2'd1, 6'd0, x, y) : 6'd0;
      checks++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb || de !== vis) begin
        failures++;
        $display("FAIL v_bars x=%0d y=%0d: rgb=%h de=%b, required rgb=%h de=%b",
                 x, y, {vga_r, vga_g, vga_b}, de, exp_rgb, vis);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_checker();
    bit ok, vis;
    int x, y;
    logic [5:0] exp_rgb;
    mode = 2'd2;
    wait_frame_start(ok);
    if (!ok) return;
    for (int off = 0; off < FRAME; off++) begin
      x = off % HT;
      y = off / HT;
      vis = (x < 16) && (y < 8);
      exp_rgb = vis ? exp_color(2'd2, 6'd0, x, y) : 6'd0;
      checks++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb || de !== vis) begin
        failures++;
        $display("FAIL checker x=%0d y=%0d: rgb=%h de=%b, required rgb=%h de=%b",
                 x, y, {vga_r, vga_g, vga_b}, de, exp_rgb, vis);
      end
      @(negedge clk);
    end
  endtask

  // Mode/colour change mid-frame must not disturb the current frame.
  task automatic test_mode_switch();
    bit ok, vis;
    int x, y;
    logic [5:0] exp_rgb;
    mode = 2'd0;
    wait_frame_start(ok);
    if (!ok) return;
    for (int off = 0; off < 2 * FRAME; off++) begin
      x = off % HT;
      y = (off / HT) % VT;
      vis = (x < 16) && (y < 8);
      exp_rgb = !vis ? 6'd0 :
                (off < FRAME) ? exp_color(2'd0, 6'd0, x, y) : exp_color(2'd3, 6'b01_10_11, x, y);
      checks++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb || frame_start !== ((off % FRAME) == 0)) begin
        failures++;
        $display("FAIL mode_switch off=%0d: rgb=%h fs=%b, required rgb=%h fs=%b",
                 off, {vga_r, vga_g, vga_b}, frame_start, exp_rgb, (off % FRAME) == 0);
      end
      if (off == 3 * HT) begin
        mode = 2'd3;
        solid_rgb = 6'b01_10_11;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_line();
    bit ok;
    wait_frame_start(ok);
    if (!ok) return;
    repeat (5 * HT + 10) @(negedge clk);
    checks++;
    if (de !== 1'b1 || px_x !== 12'd10 || px_y !== 11'd5 ||
        {vga_r, vga_g, vga_b} !== exp_color(2'd3, 6'b01_10_11, 10, 5)) begin
      failures++;
      $display("FAIL pre_reset_pixel: de=%b px=(%0d,%0d) rgb=%h, required de=1 px=(10,5) rgb=%h",
               de, px_x, px_y, {vga_r, vga_g, vga_b}, exp_color(2'd3, 6'b01_10_11, 10, 5));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({h_sync, v_sync, de, vga_r, vga_g, vga_b, px_x, px_y, frame_start} !== '0) begin
      failures++;
      $display("FAIL async_reset: hs=%b vs=%b de=%b rgb=%h px=(%0d,%0d) fs=%b, required all 0",
               h_sync, v_sync, de, {vga_r, vga_g, vga_b}, px_x, px_y, frame_start);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h_sync, v_sync, de, vga_r, vga_g, vga_b, px_x, px_y, frame_start} !== '0) begin
      failures++;
      $display("FAIL reset_hold: hs=%b vs=%b de=%b rgb=%h fs=%b, required all 0",
               h_sync, v_sync, de, {vga_r, vga_g, vga_b}, frame_start);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0 || de !== 1'b0) begin
      failures++;
      $display("FAIL mid_release_first_edge: fs=%b de=%b, required fs=0 de=0", frame_start, de);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || de !== 1'b1 || px_x !== 12'd0 || px_y !== 11'd0 ||
        {vga_r, vga_g, vga_b} !== exp_color(2'd3, 6'b01_10_11, 0, 0)) begin
      failures++;
      $display("FAIL mid_release_second_edge: fs=%b de=%b px=(%0d,%0d) rgb=%h, required fs=1 de=1 px=(0,0) rgb=%h",
               frame_start, de, px_x, px_y, {vga_r, vga_g, vga_b}, exp_color(2'd3, 6'b01_10_11, 0, 0));
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0 || px_x !== 12'd1 || px_y !== 11'd0) begin
      failures++;
      $display("FAIL mid_release_third_edge: fs=%b px=(%0d,%0d), required fs=0 px=(1,0)",
               frame_start, px_x, px_y);
    end
  endtask

`ifdef VGA_BORDER_EN
  task automatic test_border();
    bit ok, vis, edge_px;
    int x, y;
    logic [5:0] exp_rgb;
    mode = 2'd3;
    solid_rgb = 6'd0;
    wait_frame_start(ok);
    if (!ok) return;
    for (int off = 0; off < FRAME; off++) begin
      x = off % HT;
      y = off / HT;
      vis = (x < 16) && (y < 8);
      edge_px = (x == 0) || (x == 15) || (y == 0) || (y == 7);
      exp_rgb = (vis && edge_px) ? 6'h3f : 6'h00;
      checks++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb) begin
        failures++;
        $display("FAIL border x=%0d y=%0d: rgb=%h, required %h", x, y, {vga_r, vga_g, vga_b}, exp_rgb);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_v_bars();
    test_checker();
    test_mode_switch();
    test_reset_mid_line();
`ifdef VGA_BORDER_EN
    test_border();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 40/128/88; V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 600/1/4/23.
REQ-003 SHALL have parameter SYNC_POL, default 1: sync active level (1 = active-high).
REQ-004 SHALL have parameters COLOR_W, default 1 (bits per channel), and CHECK_LOG2, default 5 (log2 checker square size, px).
REQ-005 SHALL have ports: clk in 1 pixel clock; rst_n in 1 asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports: mode in 2 pattern select; solid_rgb in 3*COLOR_W solid colour {r,g,b}.
REQ-007 SHALL have ports: h_sync, v_sync out 1; de out 1 display enable; vga_r, vga_g, vga_b out COLOR_W each.
REQ-008 SHALL have ports: px_x out 12, px_y out 11 current visible coordinate; frame_start out 1 one-cycle pulse.

Function
REQ-009 SHALL count h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrapping to 0; v_cnt increments only on h wrap, wrapping 0..V_TOTAL-1.
REQ-010 SHALL assert h_sync=SYNC_POL while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; v_sync likewise on v_cnt; else !SYNC_POL.
REQ-011 SHALL drive de=1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; vga_r/g/b SHALL be 0 whenever de=0.
REQ-012 SHALL register all outputs exactly one clk after counters; h_sync, v_sync, de, colour, px_x/px_y mutually aligned (same cycle).
REQ-013 SHALL pulse frame_start for one cycle, aligned with de of pixel (0,0).
REQ-014 SHALL latch mode and solid_rgb only when h_cnt=0 and v_cnt=0; mid-frame changes take effect next frame.
REQ-015 mode 0 (H_BARS): band = v_cnt*8/V_ACTIVE (0..7) via compare against precomputed thresholds, no divider.
REQ-016 mode 1 (V_BARS): band = h_cnt*8/H_ACTIVE, same method.
REQ-017 band colour order 0..7: black, red, yellow, green, cyan, blue, magenta, white; "on" channel = all ones of COLOR_W.
REQ-018 mode 2 (CHECKER): white if h_cnt[CHECK_LOG2] XOR v_cnt[CHECK_LOG2], else black.
REQ-019 mode 3 (SOLID): colour = latched solid_rgb.
REQ-020 px_x/px_y SHALL be 0 when de=0.

Reset
REQ-021 While rst_n=0: counters 0, h_sync=v_sync=!SYNC_POL, de=0, colours 0, px 0, frame_start 0, latched mode=0.
REQ-022 Reset assertion mid-line SHALL take effect immediately (async); after release, first clk edge starts at h_cnt=0,v_cnt=0, and frame_start follows one clk later.

Configuration
REQ-023 Macro VGA_BORDER_EN defined: visible pixels with h_cnt∈{0,H_ACTIVE-1} or v_cnt∈{0,V_ACTIVE-1} SHALL be white, overriding every mode.
REQ-024 Macro undefined: no border logic; pattern colours unchanged at edges.

Structure
REQ-025 Package vga_pkg SHALL hold mode enum (H_BARS, V_BARS, CHECKER, SOLID), 8-entry colour table, default 800x600@60 timing constants.
REQ-026 Sub-module vga_timing SHALL contain counters, sync, de, frame_start; vga_pattern_gen instantiates it and adds colour logic.

Verification (bench params H 16/2/3/3, V 8/1/2/1, SYNC_POL 1, COLOR_W 2, CHECK_LOG2 2)
REQ-027 Free-run 2 frames -> H_TOTAL=24, V_TOTAL=12; h_sync high 3 cycles starting at registered h_cnt=18; de high 16x8 per frame; frame_start period 288 clk.
REQ-028 mode=0 -> rows 0..7 show black, red(3,0,0), yellow, green, cyan, blue, magenta, white(3,3,3); blanking colour 0.
REQ-029 mode=2 -> pixel (4,0)=white, (0,0)=black, (4,4)=black.
REQ-030 Switch mode 0->3 with solid_rgb=6'b01_10_11 at v_cnt=3 -> current frame stays bars; next frame all visible pixels (1,2,3).
REQ-031 Assert rst_n=0 at h_cnt=10,v_cnt=5 for 3 clk -> outputs at REQ-021 values same edge; frame_start one clk after first post-release edge.
REQ-032 With VGA_BORDER_EN, mode=3, solid 0 -> pixels (0,y),(15,y),(x,0),(x,7) = (3,3,3), interior 0.
